// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the MIPS architectural register bank.
package regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, r0 forcing, optional WB forwarding
// and pending-write lookup.
module regfile_read_port #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]               addr,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   regs,
    input  logic [(2**ADDR_W)-1:0]          busy,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               wa,
    input  logic [DATA_W-1:0]               wd,
    output logic [DATA_W-1:0]               data,
    output logic                            busy_flag
);
    import regfile_pkg::*;

    localparam int N = 2**ADDR_W;

    always_comb begin
        data      = '0;
        busy_flag = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (addr == ADDR_W'(i)) begin
                data      = regs[i*DATA_W +: DATA_W];
                busy_flag = busy[i];
            end
        end
        if (addr == '0) begin
            data      = '0;
            busy_flag = 1'b0;
        end
        // wa != 0 guarantees r0 is never forwarded
        if (BYPASS != 0 && we && wa != '0 && wa == addr)
            data = wd;
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register bank with one WB write port, two combinational read
// ports and a per-register pending-write scoreboard for the hazard unit.
module register_file #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] pa,
    output logic [DATA_W-1:0] pb,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy_a,
    output logic              busy_b
);
    import regfile_pkg::*;

    localparam int N = 2**ADDR_W;

    logic [N*DATA_W-1:0] regs;
    logic [N-1:0]        busy;
    logic                fwd_en;

    // r0 slice and busy[0] are never written, so they stay 0 after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (we && wa != '0) begin
                regs[int'(wa)*DATA_W +: DATA_W] <= wd;
                busy[wa]                        <= 1'b0;
            end
            // a set on the same register overrides the clear: a newer writer is pending
            if (busy_set && busy_addr != '0)
                busy[busy_addr] <= 1'b1;
        end
    end

    // forwarding is suppressed while reset holds the outputs at 0
    assign fwd_en = we & ~reset;

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
        .addr      (ra),
        .regs      (regs),
        .busy      (busy),
        .we        (fwd_en),
        .wa        (wa),
        .wd        (wd),
        .data      (pa),
        .busy_flag (busy_a)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
        .addr      (rb),
        .regs      (regs),
        .busy      (busy),
        .we        (fwd_en),
        .wa        (wa),
        .wd        (wd),
        .data      (pb),
        .busy_flag (busy_b)
    );

endmodule
